// File: rtl/eth_pll_reset_sequencer_pkg.sv
// eth_rst_pkg: shared definitions for the Ethernet PLL reset sequencer.
// Holds the sequencer state encoding, common widths and a small helper
// used to size the shared dwell counter.
package eth_rst_pkg;

  localparam int STATE_W    = 3;
  localparam int LOSS_CNT_W = 8;
  localparam int RETRY_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST    = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    PHY_RST    = 3'd3,
    PHY_SETTLE = 3'd4,
    RUN        = 3'd5
  } state_e;

  // Larger of two integers, used for elaboration-time sizing.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_pll_reset_sequencer_sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchronizer with synchronous,
// active-high reset to 0.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset
//   d   - asynchronous input
//   q   - synchronized output (2-cycle latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eth_pll_reset_sequencer.sv
// eth_pll_reset_sequencer: sequences Ethernet PLL reset, lock
// qualification, PHY hardware reset and MAC-side reset release, and
// re-sequences whenever the PLL loses lock. Runs on the free-running
// reference clock, never on the PLL output.
// Optional feature macro: ETH_RST_LOCK_LOSS_CNT_EN builds the saturating
// lock-loss counter; without it lock_loss_cnt is tied to zero.
// Ports:
//   clk           - free-running 125 MHz reference
//   rst           - synchronous active-high block reset
//   pll_locked    - PLL locked, asynchronous to clk
//   pll_rst       - PLL reset, active-high
//   phy_rst_n     - PHY hardware reset, active-low
//   eth_rst       - MAC/UDP reset, active-high
//   ready         - high only in RUN
//   fail          - sticky, retry count reached MAX_RETRIES
//   state_o       - current state encoding (debug)
//   lock_loss_cnt - saturating count of lock losses after qualification
module eth_pll_reset_sequencer
  import eth_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int PHY_RST_CYCLES      = 1250000,
  parameter int PHY_SETTLE_CYCLES   = 625000,
  parameter int MAX_RETRIES         = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  phy_rst_n,
  output logic                  eth_rst,
  output logic                  ready,
  output logic                  fail,
  output logic [STATE_W-1:0]    state_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_CYC = max2(max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                     max2(LOCK_STABLE_CYCLES, PHY_RST_CYCLES)),
                                PHY_SETTLE_CYCLES);
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  logic                 lk;
  logic [STATE_W-1:0]   state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [RETRY_W-1:0]   retry, retry_n;
  logic                 fail_n;
  logic                 timer_done;
  logic                 pll_rst_n_next, phy_rst_n_next, eth_rst_n_next, ready_n_next;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // Counter load is dwell-1 so that a state lasts exactly its dwell count.
  function automatic logic [CNT_W-1:0] load_for(input logic [STATE_W-1:0] s);
    case (s)
      PLL_RST:    return CNT_W'(PLL_RST_CYCLES - 1);
      WAIT_LOCK:  return CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
      STABLE:     return CNT_W'(LOCK_STABLE_CYCLES - 1);
      PHY_RST:    return CNT_W'(PHY_RST_CYCLES - 1);
      PHY_SETTLE: return CNT_W'(PHY_SETTLE_CYCLES - 1);
      default:    return {CNT_W{1'b0}};
    endcase
  endfunction

  assign timer_done = (cnt == {CNT_W{1'b0}});

  // Next-state, counter and retry logic; lock loss takes priority over expiry.
  always_comb begin
    state_n = state;
    retry_n = retry;
    case (state)
      PLL_RST: begin
        if (timer_done) state_n = WAIT_LOCK;
        else            state_n = state;
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_n = STABLE;
        end else if (timer_done) begin
          state_n = PLL_RST;
          if (retry != {RETRY_W{1'b1}}) retry_n = retry + RETRY_W'(1);
          else                          retry_n = retry;
        end else begin
          state_n = state;
        end
      end
      STABLE: begin
        if (!lk) begin
          state_n = WAIT_LOCK;
        end else if (timer_done) begin
          state_n = PHY_RST;
          retry_n = {RETRY_W{1'b0}};
        end else begin
          state_n = state;
        end
      end
      PHY_RST: begin
        if (!lk)             state_n = WAIT_LOCK;
        else if (timer_done) state_n = PHY_SETTLE;
        else                 state_n = state;
      end
      PHY_SETTLE: begin
        if (!lk)             state_n = WAIT_LOCK;
        else if (timer_done) state_n = RUN;
        else                 state_n = state;
      end
      RUN: begin
        if (!lk) state_n = WAIT_LOCK;
        else     state_n = state;
      end
      default: state_n = PLL_RST;
    endcase

    // Every state change (including the STABLE -> WAIT_LOCK fallback) reloads.
    if (state_n != state)  cnt_n = load_for(state_n);
    else if (!timer_done)  cnt_n = cnt - CNT_W'(1);
    else                   cnt_n = cnt;

    fail_n = fail | (retry_n >= RETRY_W'(MAX_RETRIES));
  end

  // Output levels as a function of the state being entered.
  always_comb begin
    pll_rst_n_next = 1'b0;
    phy_rst_n_next = 1'b0;
    eth_rst_n_next = 1'b1;
    ready_n_next   = 1'b0;
    case (state_n)
      PLL_RST:    pll_rst_n_next = 1'b1;
      PHY_SETTLE: phy_rst_n_next = 1'b1;
      RUN: begin
        phy_rst_n_next = 1'b1;
        eth_rst_n_next = 1'b0;
        ready_n_next   = 1'b1;
      end
      default: pll_rst_n_next = 1'b0;
    endcase
  end

  // State, counter and registered outputs; reset counts as entry into PLL_RST,
  // so the counter is preloaded with the PLL reset dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLL_RST;
      cnt       <= CNT_W'(PLL_RST_CYCLES - 1);
      retry     <= {RETRY_W{1'b0}};
      fail      <= 1'b0;
      pll_rst   <= 1'b1;
      phy_rst_n <= 1'b0;
      eth_rst   <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      fail      <= fail_n;
      pll_rst   <= pll_rst_n_next;
      phy_rst_n <= phy_rst_n_next;
      eth_rst   <= eth_rst_n_next;
      ready     <= ready_n_next;
    end
  end

  assign state_o = state;

`ifdef ETH_RST_LOCK_LOSS_CNT_EN
  logic                  lock_loss;
  logic [LOSS_CNT_W-1:0] loss_cnt;

  // Only losses after qualification count; STABLE and WAIT_LOCK drops do not.
  assign lock_loss = !lk && ((state == PHY_RST) || (state == PHY_SETTLE) || (state == RUN));

  // Saturating lock-loss counter.
  always_ff @(posedge clk) begin
    if (rst)                                        loss_cnt <= {LOSS_CNT_W{1'b0}};
    else if (lock_loss && (loss_cnt != {LOSS_CNT_W{1'b1}})) loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
    else                                            loss_cnt <= loss_cnt;
  end

  assign lock_loss_cnt = loss_cnt;
`else
  assign lock_loss_cnt = {LOSS_CNT_W{1'b0}};
`endif

endmodule
